// File: rtl/gates_vector_checker.sv
// gates_vector_checker: sweeps (a,b) = 00..11 through the gates block and checks
// each response against a golden model, reporting pass, error count and fail detail.
module gates_vector_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_CNT_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 a,
  output logic                 b,
  input  logic [7:0]           gate_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [3:0]           fail_mask,
  output logic [7:0]           first_fail_xor
);
  localparam int CW = SETTLE_CYCLES > 0 ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] SETTLE = CW'(SETTLE_CYCLES);
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  state_t r_state, w_next;
  logic [1:0] r_vec;
  logic [CW-1:0] r_cnt;
  logic [ERR_CNT_W-1:0] r_err;
  logic [3:0] r_mask, w_mask;
  logic [7:0] r_ffx, w_exp, w_diff;
  logic r_pass, w_a, w_b, w_sample, w_bad;
  always_ff @(posedge clk) r_state <= !rst_n ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE  ? (start ? DRIVE : IDLE) :
             r_state == DRIVE ? ((w_sample && r_vec == 2'd3) ? DONE : DRIVE) : IDLE;
  end
  assign w_a      = (r_state == DRIVE) & r_vec[1];
  assign w_b      = (r_state == DRIVE) & r_vec[0];
  assign w_sample = (r_state == DRIVE) && (r_cnt == SETTLE);
  assign w_exp    = {~(w_a ^ w_b), ~(w_a | w_b), ~(w_a & w_b), ~w_a, w_a ^ w_b, w_a | w_b, w_a & w_b, w_a};
  assign w_diff   = gate_out ^ w_exp;
  assign w_bad    = |w_diff;
  assign w_mask   = r_mask | ({3'b000, w_bad} << r_vec);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vec  <= '0;
      r_cnt  <= '0;
      r_err  <= '0;
      r_mask <= '0;
      r_ffx  <= '0;
      r_pass <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_vec  <= '0;
      r_cnt  <= '0;
      r_err  <= '0;
      r_mask <= '0;
      r_ffx  <= '0;
      r_pass <= 1'b0;
    end else if (r_state == DRIVE) begin
      r_cnt <= w_sample ? '0 : r_cnt + 1'b1;
      if (w_sample) begin
        r_mask <= w_mask;
        r_vec  <= r_vec + 1'b1;
        if (w_bad && r_err != '1) r_err <= r_err + 1'b1;
        // only the lowest-index failing vector is captured
        if (w_bad && r_mask == 4'd0) r_ffx <= w_diff;
        if (r_vec == 2'd3) r_pass <= (w_mask == 4'd0);
      end
    end
  end
  assign a              = w_a;
  assign b              = w_b;
  assign busy           = r_state != IDLE;
  assign done           = r_state == DONE;
  assign pass           = r_pass;
  assign err_count      = r_err;
  assign fail_mask      = r_mask;
  assign first_fail_xor = r_ffx;
endmodule
